regfile_write_arbiter: RTL



---
 rtl/regfile_write_arbiter.sv | 112 +++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port among NREQ write-back
// requesters, with one registered output stage, x0 suppression, hold and a write counter.
module regfile_write_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32,
  localparam int GW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NREQ-1:0]  io_req_valid,
  output logic [NREQ-1:0]  io_req_ready,
  input  logic [NREQ*AW-1:0] io_req_addr,
  input  logic [NREQ*DW-1:0] io_req_data,
  input  logic             io_hold,
  output logic             io_rf_wen,
  output logic [AW-1:0]    io_rf_waddr,
  output logic [DW-1:0]    io_rf_wdata,
  output logic [GW-1:0]    io_grant_id,
  output logic [15:0]      io_write_count
);

  localparam int CW = GW + 1;

  logic [GW-1:0] prio_q, prio_d;
  logic          wen_q, wen_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [GW-1:0] gid_q, gid_d;
  logic [15:0]   count_q, count_d;

  logic          grantHit;
  logic [GW-1:0] grantIdx;
  logic [CW-1:0] cand;
  logic [AW-1:0] selAddr;
  logic [DW-1:0] selData;

  // Scan from the priority pointer, wrapping modulo NREQ; first valid requester wins.
  always_comb begin
    grantHit = 1'b0;
    grantIdx = '0;
    cand     = '0;
    if (!reset && !io_hold) begin
      for (int k = 0; k < NREQ; k++) begin
        cand = {1'b0, prio_q} + CW'(k);
        if (cand >= CW'(NREQ)) cand = cand - CW'(NREQ);
        if (!grantHit && io_req_valid[cand[GW-1:0]]) begin
          grantHit = 1'b1;
          grantIdx = cand[GW-1:0];
        end
      end
    end
  end

  always_comb begin
    io_req_ready = '0;
    selAddr      = '0;
    selData      = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grantIdx == GW'(i)) begin
        io_req_ready[i] = grantHit;
        selAddr         = io_req_addr[i*AW +: AW];
        selData         = io_req_data[i*DW +: DW];
      end
    end
  end

  // Reset gates the enable combinationally so a write sitting in the stage is dropped.
  assign io_rf_wen      = wen_q & ~reset;
  assign io_rf_waddr    = waddr_q;
  assign io_rf_wdata    = wdata_q;
  assign io_grant_id    = gid_q;
  assign io_write_count = count_q;

  always_comb begin
    prio_d  = prio_q;
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    gid_d   = gid_q;
    count_d = count_q;
    if (grantHit) begin
      prio_d  = (grantIdx == GW'(NREQ - 1)) ? '0 : grantIdx + GW'(1);
      wen_d   = (selAddr != '0);
      waddr_d = selAddr;
      wdata_d = selData;
      gid_d   = grantIdx;
    end
    if (io_rf_wen && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prio_q  <= '0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      gid_q   <= '0;
      count_q <= '0;
    end else begin
      prio_q  <= prio_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      gid_q   <= gid_d;
      count_q <= count_d;
    end
  end

endmodule
